// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver.
// The serial line passes through a 2-FF synchroniser and is sampled on an
// internal oversample tick. The receiver decodes the start, data, parity and
// stop fields LSB-first. Each frame is presented on a valid/ready output
// register, together with its parity and framing flags.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   rx_in        async serial line, idle high
//   rx_data      received word, LSB = first bit on the line
//   rx_valid     rx_data/flags valid, held until accepted
//   rx_ready     consumer accepts when rx_valid && rx_ready
//   parity_err   parity mismatch for the frame in rx_data
//   frame_err    a checked stop bit was sampled low for the frame in rx_data
//   overrun_err  1-clk pulse, a completed frame was dropped
//   busy         high from start detect to the final stop sample
//
// state  | meaning
// IDLE   | waiting for a start edge (only once the line has been seen high)
// START  | checking the middle of the start bit, rejecting glitches
// DATA   | sampling DATA_BITS data bits at bit centres
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit(s), then committing the frame
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_o_q, perr_o_d;
  logic                 ferr_o_q, ferr_o_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, rx_s, commit;

  assign rx_s = sync2_q;
  assign tick = (tcnt_q == T_LAST);

  // State register process
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      s_q      <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      armed_q  <= 1'b0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      s_q      <= s_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      armed_q  <= armed_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state process
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
    s_d      = s_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    armed_d  = armed_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A line that is still low after a break must not start a new frame.
        if (tick && rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d = S_START;
          s_d     = '0;
          armed_d = 1'b0;
        end
      end
      S_START: if (tick) begin
        if (s_q == S_HALF) begin
          s_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else s_d = s_q + SW'(1);
      end
      S_DATA: if (tick) begin
        if (s_q == S_FULL) begin
          s_d     = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          stop_d  = 1'b0;
          if (bit_q == B_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else s_d = s_q + SW'(1);
      end
      S_PARITY: if (tick) begin
        if (s_q == S_FULL) begin
          s_d     = '0;
          perr_d  = (^shift_q) ^ rx_s ^ ODD;
          state_d = S_STOP;
        end else s_d = s_q + SW'(1);
      end
      S_STOP: if (tick) begin
        if (s_q == S_FULL) begin
          s_d    = '0;
          ferr_d = ferr_q | ~rx_s;
          if (stop_q == STOP_LAST) begin
            commit  = 1'b1;
            state_d = S_IDLE;
            // A high stop sample already proves the line is idle, so the next start
            // can be taken at once. A low stop sample (break) leaves the receiver disarmed.
            armed_d = rx_s;
          end else stop_d = stop_q + 1'b1;
        end else s_d = s_q + SW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = 1'b0;
    if (commit && (!valid_q || rx_ready)) begin
      data_d   = shift_q;
      perr_o_d = perr_q;
      ferr_o_d = ferr_q | ~rx_s;
      valid_d  = 1'b1;
    end else if (commit) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output process
  always_comb begin
    busy        = (state_q != S_IDLE);
    rx_data     = data_q;
    rx_valid    = valid_q;
    parity_err  = perr_o_q;
    frame_err   = ferr_o_q;
    overrun_err = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core.
// Configuration: 8E1, CLK_DIV=4, OVERSAMPLE=16, so one bit lasts 64 clk.
// Stimulus pushes the expected frames into a queue. The monitor compares
// each accepted frame against the queue, and it also checks the pulse width
// of overrun_err.
module tb_uart_rx_core;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;

  always #5 clk = ~clk;

  uart_rx_core #(
    .DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   ovr_seen = 0;
  int   ovr_exp = 0;
  logic prev_hs = 1'b0;
  logic prev_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted frame.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_hs  = 1'b0;
      prev_ovr = 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        chk("valid_width", {31'b0, prev_hs}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", {24'b0, rx_data}, {24'b0, e.d});
          chk("parity_err", {31'b0, parity_err}, {31'b0, e.pe});
          chk("frame_err", {31'b0, frame_err}, {31'b0, e.fe});
        end
        prev_hs = 1'b1;
      end else begin
        prev_hs = 1'b0;
      end
      if (overrun_err) begin
        ovr_seen++;
        chk("overrun_width", {31'b0, prev_ovr}, 32'd0);
      end
      prev_ovr = overrun_err;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives the first nbits of {stop, parity, data, start} onto the line, LSB first.
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_in = f[i];
      wclk(BIT_CLKS);
    end
    rx_in = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic stp,
                       input logic pe, input logic fe);
    exp_q.push_back({d, pe, fe});
    send(d, par, stp, 11);
    wclk(40);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
    chk({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'd0);
    chk({tag, "_parity_err"}, {31'b0, parity_err}, 32'd0);
    chk({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    chk({tag, "_overrun_err"}, {31'b0, overrun_err}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1 chk_all_zero("reset");
    wclk(3);
    rstn = 1'b1;
    wclk(20);

    // 1: clean 0xA5
    frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    // 2: 0x3C with a wrong parity bit
    frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    // 3: 0x55 with a low stop bit, then the line returns high
    frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    wclk(100);

    // 4: 20-clk low glitch, followed by a good frame
    rx_in = 1'b0;
    wclk(10);
    chk("glitch_busy_high", {31'b0, busy}, 32'd1);
    wclk(10);
    rx_in = 1'b1;
    wclk(80);
    chk("glitch_busy_low", {31'b0, busy}, 32'd0);
    chk("glitch_no_valid", {31'b0, rx_valid}, 32'd0);
    frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: overrun while the consumer stalls
    rx_ready = 1'b0;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send(8'h11, 1'b0, 1'b1, 11);
    wclk(20);
    ovr_exp = 1;
    send(8'h22, 1'b0, 1'b1, 11);
    wclk(40);
    chk("ovr_valid_held", {31'b0, rx_valid}, 32'd1);
    chk("ovr_data_kept", {24'b0, rx_data}, 32'h11);
    chk("ovr_pulse_seen", ovr_seen, 32'd1);
    rx_ready = 1'b1;
    wclk(3);
    chk("accept_valid_low", {31'b0, rx_valid}, 32'd0);
    chk("accept_data_hold", {24'b0, rx_data}, 32'h11);

    // 6: reset in the middle of the data bits of 0xF0
    send(8'hF0, 1'b0, 1'b1, 4);
    rx_in = 1'b0;
    #1 rstn = 1'b0;
    #1 chk_all_zero("midreset");
    rx_in = 1'b1;
    wclk(3);
    rstn = 1'b1;
    wclk(20);
    frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);

    wclk(20);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("overrun_count", ovr_seen, ovr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
